minisys_soc: RTL and testbench

Minimal single-cycle Minisys (MIPS-subset) CPU system with its memories and board I/O in one block. It fetches from an internal instruction ROM, executes a reduced MIPS-I integer ISA and maps a 24-bit switch bank, a 24-bit LED bank and an 8-digit seven-segment display into the top of the address space. It is the FPGA top level and the unit simulated by the system bench.

---
 rtl/minisys_soc.sv | 148 ++++++++++++++
 tb/tb_minisys_soc.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/minisys_soc.sv
module minisys_soc #(
   parameter     PROG_FILE  = "prog.hex",
   parameter int IMEM_WORDS = 256,
   parameter int DMEM_WORDS = 64,
   parameter int SCAN_DIV   = 50000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [23:0] switch2N4,
   output logic [23:0] led2N4,
   output logic [7:0]  tube_data,
   output logic [7:0]  tube_addr
);
   localparam int IW = $clog2(IMEM_WORDS);
   localparam int DW = $clog2(DMEM_WORDS);
   localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [31:0] PC_MASK = 32'(IMEM_WORDS * 4 - 1);
   localparam logic [7:0] GLYPH [16] = '{
      8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
      8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

   logic [31:0] imem [IMEM_WORDS];
   logic [31:0] dmem [DMEM_WORDS];
   logic [31:0] regs [32];
   logic [31:0] pc, disp_val;
   logic [CW-1:0] scan_cnt;
   logic [2:0]  dig;

   logic [31:0] instr, rs_v, rt_v, sext, zext, ea, pc4, br_tgt;
   logic [31:0] mem_rd, next_pc, wb_data;
   logic [5:0]  op, fn;
   logic [4:0]  rs, rt, rd, sh, wb_addr;
   logic        wb_en, ram_we, led_we, disp_we, is_io;

   assign instr = imem[pc[2 +: IW]];
   assign {op, rs, rt, rd, sh, fn} = instr;
   assign rs_v   = (rs == 5'd0) ? 32'd0 : regs[rs];
   assign rt_v   = (rt == 5'd0) ? 32'd0 : regs[rt];
   assign sext   = {{16{instr[15]}}, instr[15:0]};
   assign zext   = {16'd0, instr[15:0]};
   // Word access only: the byte offset is dropped before any decode.
   assign ea     = (rs_v + sext) & ~32'd3;
   assign is_io  = (ea[31:10] == 22'h3FFFFF);
   assign pc4    = pc + 32'd4;
   assign br_tgt = pc4 + {sext[29:0], 2'b00};

   always_comb begin
      mem_rd = 32'd0;
      if (!is_io)                  mem_rd = dmem[ea[2 +: DW]];
      else if (ea == 32'hFFFFFC70) mem_rd = {8'h00, switch2N4};
      else if (ea == 32'hFFFFFC60) mem_rd = {8'h00, led2N4};
      else if (ea == 32'hFFFFFC00) mem_rd = disp_val;
   end

   always_comb begin
      wb_en   = 1'b0;
      wb_addr = rt;
      wb_data = 32'd0;
      next_pc = pc4;
      ram_we  = 1'b0;
      led_we  = 1'b0;
      disp_we = 1'b0;
      case (op)
         6'h00: begin
            wb_en   = 1'b1;
            wb_addr = rd;
            case (fn)
               6'h20, 6'h21: wb_data = rs_v + rt_v;
               6'h22, 6'h23: wb_data = rs_v - rt_v;
               6'h24: wb_data = rs_v & rt_v;
               6'h25: wb_data = rs_v | rt_v;
               6'h26: wb_data = rs_v ^ rt_v;
               6'h27: wb_data = ~(rs_v | rt_v);
               6'h2A: wb_data = {31'd0, $signed(rs_v) < $signed(rt_v)};
               6'h2B: wb_data = {31'd0, rs_v < rt_v};
               6'h00: wb_data = rt_v << sh;
               6'h02: wb_data = rt_v >> sh;
               6'h03: wb_data = $signed(rt_v) >>> sh;
               6'h08: begin
                  wb_en   = 1'b0;
                  next_pc = rs_v;
               end
               default: wb_en = 1'b0;
            endcase
         end
         6'h08, 6'h09: begin wb_en = 1'b1; wb_data = rs_v + sext; end
         6'h0C: begin wb_en = 1'b1; wb_data = rs_v & zext; end
         6'h0D: begin wb_en = 1'b1; wb_data = rs_v | zext; end
         6'h0E: begin wb_en = 1'b1; wb_data = rs_v ^ zext; end
         6'h0F: begin wb_en = 1'b1; wb_data = {instr[15:0], 16'd0}; end
         6'h0A: begin wb_en = 1'b1; wb_data = {31'd0, $signed(rs_v) < $signed(sext)}; end
         6'h0B: begin wb_en = 1'b1; wb_data = {31'd0, rs_v < sext}; end
         6'h23: begin wb_en = 1'b1; wb_data = mem_rd; end
         6'h2B: begin
            if (!is_io)                  ram_we  = 1'b1;
            else if (ea == 32'hFFFFFC60) led_we  = 1'b1;
            else if (ea == 32'hFFFFFC00) disp_we = 1'b1;
         end
         6'h04: if (rs_v == rt_v) next_pc = br_tgt;
         6'h05: if (rs_v != rt_v) next_pc = br_tgt;
         6'h02: next_pc = {pc4[31:28], instr[25:0], 2'b00};
         6'h03: begin
            next_pc = {pc4[31:28], instr[25:0], 2'b00};
            wb_en   = 1'b1;
            wb_addr = 5'd31;
            wb_data = pc4;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc       <= '0;
         led2N4   <= '0;
         disp_val <= '0;
         for (int i = 0; i < 32; i++) regs[i] <= '0;
      end else begin
         pc <= next_pc & PC_MASK;
         if (wb_en && wb_addr != 5'd0) regs[wb_addr] <= wb_data;
         if (led_we)  led2N4   <= rt_v[23:0];
         if (disp_we) disp_val <= rt_v;
      end
   end

   // RAM is not reset; the rst gate keeps a held-in-reset fetch from storing.
   always_ff @(posedge clk) begin
      if (ram_we && rst) dmem[ea[2 +: DW]] <= rt_v;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         scan_cnt  <= '0;
         dig       <= '0;
         tube_addr <= 8'hFF;
         tube_data <= 8'hFF;
      end else begin
         if (scan_cnt == CW'(SCAN_DIV - 1)) begin
            scan_cnt <= '0;
            dig      <= dig + 3'd1;
         end else begin
            scan_cnt <= scan_cnt + CW'(1);
         end
         tube_addr <= ~(8'd1 << dig);
         tube_data <= GLYPH[disp_val[4*dig +: 4]];
      end
   end
endmodule

// File: tb/tb_minisys_soc.sv
// Scoreboard bench for minisys_soc: directed programs poked into the ROM,
// expected LED/display transitions queued and checked by independent monitors.
module tb_minisys_soc;
   logic        clk, rst;
   logic [23:0] sw, led;
   logic [7:0]  tdata, taddr;
   int          n_cmp = 0, n_bad = 0;
   logic [23:0] exp_led[$];
   logic [15:0] exp_tube[$];
   logic [31:0] prog[$];
   logic [23:0] cur_led = '0;
   logic        tube_on = 1'b0;

   minisys_soc #(.SCAN_DIV(4)) dut (
      .clk(clk), .rst(rst), .switch2N4(sw), .led2N4(led),
      .tube_data(tdata), .tube_addr(taddr));

   initial begin
      clk = 1'b0;
      forever #10 clk = ~clk;
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, want %h", nm, act, exp);
      end
   endtask

   task automatic push_led(input logic [23:0] v);
      exp_led.push_back(v);
      cur_led = v;
   endtask

   task automatic load();
      for (int i = 0; i < 256; i++) dut.imem[i] = (i < prog.size()) ? prog[i] : 32'h0;
   endtask

   task automatic hold_reset();
      @(negedge clk);
      if (cur_led != 24'h0) push_led(24'h0);
      rst = 1'b0;
   endtask

   task automatic release_rst();
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic drain(input string nm);
      @(posedge clk);
      check(nm, exp_led.size(), 0);
   endtask

   initial begin : led_mon
      logic [23:0] prev, e;
      prev = '0;
      forever begin
         @(negedge clk);
         if (led !== prev) begin
            if (exp_led.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL led_unexpected: got %h, nothing queued", led);
            end else begin
               e = exp_led.pop_front();
               check("led", {8'h0, led}, {8'h0, e});
            end
            prev = led;
         end
      end
   end

   initial begin : tube_mon
      logic [15:0] prev_t, cur_t, e;
      int dwell;
      logic dv;
      prev_t = '0;
      dwell  = 0;
      dv     = 1'b0;
      forever begin
         @(negedge clk);
         cur_t = {taddr, tdata};
         if (!tube_on) begin
            prev_t = cur_t;
            dwell  = 0;
            dv     = 1'b0;
         end else begin
            dwell++;
            if (cur_t !== prev_t) begin
               if (exp_tube.size() == 0) begin
                  n_cmp++;
                  n_bad++;
                  $display("FAIL tube_unexpected: got %h, nothing queued", cur_t);
               end else begin
                  e = exp_tube.pop_front();
                  check("tube", 32'(cur_t), 32'(e));
               end
               if (dv) check("tube_dwell", dwell, 4);
               prev_t = cur_t;
               dwell  = 0;
               dv     = 1'b1;
            end
         end
      end
   end

   initial begin : stim
      logic [23:0] led_or;
      logic [7:0]  ta_and, td_and;
      logic [31:0] pc_or;
      int t;
      rst = 1'b1;
      sw  = 24'h0;
      #1 rst = 1'b0;

      // Reset hold for 350 cycles (7 us at 50 MHz); store uses base $0 so EA hits the LED port
      prog = '{32'h34011234, 32'h3C02FFFF, 32'hAC01FC60, 32'h08000003};
      load();
      led_or = '0; ta_and = 8'hFF; td_and = 8'hFF; pc_or = '0;
      repeat (350) begin
         @(negedge clk);
         led_or |= led;
         ta_and &= taddr;
         td_and &= tdata;
         pc_or  |= dut.pc;
      end
      check("rst_led", {8'h0, led_or}, 32'h0);
      check("rst_tube_addr", {24'h0, ta_and}, 32'hFF);
      check("rst_tube_data", {24'h0, td_and}, 32'hFF);
      check("rst_pc", pc_or, 32'h0);

      release_rst();
      @(negedge clk);
      check("pc_first", dut.pc, 32'h4);
      check("tube_addr_first", {24'h0, taddr}, 32'hFE);
      check("tube_data_first", {24'h0, tdata}, 32'hC0);
      @(negedge clk);
      check("led_before_sw", {8'h0, led}, 32'h0);
      push_led(24'h001234);
      @(negedge clk);
      check("led_third_cycle", {8'h0, led}, 32'h001234);
      cycles(4);
      drain("drain_t2");

      // Switch read, LED write, LED readback + 1
      hold_reset();
      sw = 24'hA5A5A5;
      prog = '{32'h8C03FC70, 32'hAC03FC60, 32'h8C04FC60, 32'h24840001,
               32'hAC04FC60, 32'h08000005};
      load();
      push_led(24'hA5A5A5);
      push_led(24'hA5A5A6);
      cycles(2);
      release_rst();
      cycles(10);
      drain("drain_t3");

      // addi/sltu/slt, taken beq skips a store, untaken bne falls through
      hold_reset();
      prog = '{32'h2004FFFF, 32'h0004282B, 32'h0080302A, 32'h10A60001,
               32'hAC04FC60, 32'h34070042, 32'hAC07FC60, 32'h14A60001,
               32'hAC05FC60, 32'h08000009};
      load();
      push_led(24'h000042);
      push_led(24'h000001);
      cycles(2);
      release_rst();
      cycles(14);
      drain("drain_t4");

      // Shifts and logic ops: sra/srl/xor, sll/sub/nor, and
      hold_reset();
      prog = '{32'h3C018000, 32'h00011103, 32'h00021A02, 32'h34040F0F,
               32'h00642826, 32'hAC05FC60, 32'h00043100, 32'h00C43822,
               32'h00E04027, 32'hAC08FC60, 32'h01064824, 32'hAC09FC60,
               32'h0800000C};
      load();
      push_led(24'hF80F0F);
      push_led(24'hFF1E1E);
      push_led(24'h001010);
      cycles(2);
      release_rst();
      cycles(16);
      drain("drain_alu");

      // RAM round trip of DEADBEEF into the display and LEDs, then the scan
      hold_reset();
      prog = '{32'h3C01DEAD, 32'h3421BEEF, 32'hAC010010, 32'h8C020010,
               32'hAC02FC00, 32'hAC02FC60, 32'h08000006};
      load();
      push_led(24'hADBEEF);
      cycles(2);
      release_rst();
      cycles(8);
      drain("drain_t5");
      t = 0;
      while (taddr === 8'hFE && t < 20) begin @(negedge clk); t++; end
      while (taddr !== 8'hFE && t < 100) begin @(negedge clk); t++; end
      check("tube_sync", {24'h0, taddr}, 32'hFE);
      check("digit0_glyph", {24'h0, tdata}, 32'h8E);
      @(posedge clk);
      exp_tube = '{16'hFD86, 16'hFB86, 16'hF783, 16'hEFA1,
                   16'hDF88, 16'hBF86, 16'h7FA1, 16'hFE8E};
      tube_on = 1'b1;
      repeat (33) @(posedge clk);
      @(negedge clk);
      tube_on = 1'b0;
      check("tube_drain", exp_tube.size(), 0);

      // jal/jr subroutine loop, asynchronous reset mid-loop
      hold_reset();
      prog = '{32'h0C000004, 32'hAC07FC60, 32'h08000000, 32'h00000000,
               32'h24E70001, 32'h03E00008};
      load();
      for (int k = 1; k <= 5; k++) push_led(24'(k));
      cycles(2);
      release_rst();
      repeat (26) @(posedge clk);
      #3;
      push_led(24'h0);
      rst = 1'b0;
      #1;
      check("async_led", {8'h0, led}, 32'h0);
      check("async_pc", dut.pc, 32'h0);
      check("async_r7", dut.regs[7], 32'h0);
      check("async_r31", dut.regs[31], 32'h0);
      check("async_tube", {16'h0, taddr, tdata}, 32'hFFFF);
      cycles(3);
      push_led(24'h000001);
      release_rst();
      cycles(6);
      drain("drain_t6");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
